dco_param: RTL and testbench

- Parametrised counter-based digitally controlled oscillator for the ADPLL.
- Converts the signed loop-filter word into a half-period threshold and toggles `dco_clk` when the counter reaches it.
- Improvements over the 5-bit generation:
  - configurable widths;
  - full-precision signed arithmetic with saturation flags;
  - glitch-free threshold update, applied only at toggle boundaries;
  - enable and frequency-hold modes;
  - edge strobe and a power-of-two divided output for the phase detector feedback path.

---
 rtl/dco_param_if.sv | 31 +++
 rtl/dco_param.sv | 103 ++++++++++
 tb/tb_dco_param.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dco_param_if.sv
// Control and observation bundle of the parametrised ADPLL DCO.
// The master drives the loop controls; the slave (the DCO) drives the oscillator outputs.
interface dco_param_if #(
    parameter int W  = 8,
    parameter int CW = 6,
    parameter int KW = 4
);
    logic          en;
    logic          hold;
    logic [KW-1:0] kdco;
    logic          ctrl_sign;
    logic [CW-1:0] ctrl;
    logic [W-1:0]  dco_offset;
    logic [W-1:0]  thresh_val;
    logic          dco_clk;
    logic          dco_edge;
    logic          dco_div;
    logic [W-1:0]  thr_out;
    logic          sat_hi;
    logic          sat_lo;

    modport master (
        output en, hold, kdco, ctrl_sign, ctrl, dco_offset, thresh_val,
        input  dco_clk, dco_edge, dco_div, thr_out, sat_hi, sat_lo
    );

    modport slave (
        input  en, hold, kdco, ctrl_sign, ctrl, dco_offset, thresh_val,
        output dco_clk, dco_edge, dco_div, thr_out, sat_hi, sat_lo
    );
endinterface

// File: rtl/dco_param.sv
// Counter-based DCO: a counter runs from dco_offset up to the active threshold,
// then dco_clk toggles and a new clamped threshold is latched at that boundary.
module dco_param #(
    parameter int W        = 8,
    parameter int CW       = 6,
    parameter int KW       = 4,
    parameter int FRAC     = 1,
    parameter int DIV_LOG2 = 2
) (
    input  logic      clk,
    input  logic      reset,
    dco_param_if.slave bus
);
    localparam int PW = CW + KW;
    localparam int SW = ((W > PW) ? W : PW) + 2;
    localparam logic signed [SW-1:0] SAT_MAX = SW'({W{1'b1}});

    logic [PW-1:0]         w_prod;
    logic [PW-1:0]         w_phase;
    logic signed [SW-1:0]  w_sum;
    logic [W-1:0]          w_target;
    logic                  w_hi;
    logic                  w_lo;
    logic                  w_toggle;
    logic [DIV_LOG2-1:0]   w_div_next;

    logic [W-1:0]          r_cnt;
    logic [W-1:0]          r_thr;
    logic                  r_clk;
    logic                  r_edge;
    logic                  r_sat_hi;
    logic                  r_sat_lo;
    logic [DIV_LOG2-1:0]   r_div_cnt;
    logic                  r_div;

    // Target threshold: full-precision signed sum, clamped into the W-bit range.
    always_comb begin
        w_prod  = PW'(bus.ctrl) * PW'(bus.kdco);
        w_phase = w_prod >> FRAC;
        w_sum   = $signed(SW'(bus.thresh_val)) + $signed(SW'(bus.dco_offset));
        if (bus.ctrl_sign) begin
            w_sum = w_sum - $signed(SW'(w_phase));
        end else begin
            w_sum = w_sum + $signed(SW'(w_phase));
        end
        w_target = w_sum[W-1:0];
        w_hi     = 1'b0;
        w_lo     = 1'b0;
        if (w_sum[SW-1]) begin
            w_target = {W{1'b0}};
            w_lo     = 1'b1;
        end else if (w_sum > SAT_MAX) begin
            w_target = {W{1'b1}};
            w_hi     = 1'b1;
        end else begin
            w_target = w_sum[W-1:0];
        end
        w_toggle   = bus.en & (r_cnt >= r_thr);
        w_div_next = r_div_cnt + DIV_LOG2'(1'b1);
    end

    // Oscillator state: the threshold only changes on a toggle, so a half period in progress is never disturbed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= {W{1'b0}};
            r_thr     <= {W{1'b0}};
            r_clk     <= 1'b0;
            r_edge    <= 1'b0;
            r_sat_hi  <= 1'b0;
            r_sat_lo  <= 1'b0;
            r_div_cnt <= {DIV_LOG2{1'b0}};
            r_div     <= 1'b0;
        end else if (bus.en) begin
            if (w_toggle) begin
                r_clk  <= ~r_clk;
                r_edge <= 1'b1;
                r_cnt  <= bus.dco_offset;
                if (!bus.hold) begin
                    r_thr    <= w_target;
                    r_sat_hi <= w_hi;
                    r_sat_lo <= w_lo;
                end
                // Divider advances on dco_clk rising edges so dco_div rises with dco_clk.
                if (!r_clk) begin
                    r_div_cnt <= w_div_next;
                    r_div     <= w_div_next[DIV_LOG2-1];
                end
            end else begin
                r_cnt  <= r_cnt + W'(1'b1);
                r_edge <= 1'b0;
            end
        end else begin
            r_edge <= 1'b0;
        end
    end

    assign bus.dco_clk  = r_clk;
    assign bus.dco_edge = r_edge;
    assign bus.dco_div  = r_div;
    assign bus.thr_out  = r_thr;
    assign bus.sat_hi   = r_sat_hi;
    assign bus.sat_lo   = r_sat_lo;
endmodule

// File: tb/tb_dco_param.sv
// Self-checking bench for dco_param: a half-period-length reference model checked every cycle,
// plus directed period, saturation, hold, enable, divider and reset measurements.
module tb_dco_param;
    localparam int W = 8, CW = 6, KW = 4, FRAC = 1, DIV_LOG2 = 2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dco_param_if #(.W(W), .CW(CW), .KW(KW)) bus ();

    dco_param #(.W(W), .CW(CW), .KW(KW), .FRAC(FRAC), .DIV_LOG2(DIV_LOG2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: output level, remaining enabled cycles before the next toggle, latched threshold.
    bit m_clk, m_edge, m_hi, m_lo;
    int m_thr, m_rem, m_rises;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        int period;
        period = 1 << DIV_LOG2;
        chk({tag, ".dco_clk"},  32'(bus.dco_clk),  32'(m_clk));
        chk({tag, ".dco_edge"}, 32'(bus.dco_edge), 32'(m_edge));
        chk({tag, ".dco_div"},  32'(bus.dco_div),  32'((m_rises % period) >= (period / 2)));
        chk({tag, ".thr_out"},  32'(bus.thr_out),  32'(m_thr));
        chk({tag, ".sat_hi"},   32'(bus.sat_hi),   32'(m_hi));
        chk({tag, ".sat_lo"},   32'(bus.sat_lo),   32'(m_lo));
    endtask

    task automatic model_reset();
        m_clk = 0; m_edge = 0; m_hi = 0; m_lo = 0;
        m_thr = 0; m_rem = 0; m_rises = 0;
    endtask

    // One clock with the inputs currently applied; the model predicts, then the DUT is checked.
    task automatic cyc(input string tag);
        int phase, sum, tgt, maxv, off;
        bit thi, tlo;
        maxv  = (1 << W) - 1;
        off   = int'(bus.dco_offset);
        phase = (int'(bus.ctrl) * int'(bus.kdco)) >>> FRAC;
        sum   = int'(bus.thresh_val) + off + (bus.ctrl_sign ? -phase : phase);
        thi   = sum > maxv;
        tlo   = sum < 0;
        tgt   = thi ? maxv : (tlo ? 0 : sum);
        m_edge = 0;
        if (bus.en) begin
            if (m_rem == 0) begin
                m_clk  = !m_clk;
                m_edge = 1;
                if (m_clk) m_rises++;
                if (!bus.hold) begin
                    m_thr = tgt; m_hi = thi; m_lo = tlo;
                end
                m_rem = (m_thr > off) ? m_thr - off : 0;
            end else begin
                m_rem--;
            end
        end
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic sync_edge(input string tag);
        int n = 0;
        do begin
            cyc(tag);
            n++;
        end while (bus.dco_edge !== 1'b1 && n < 600);
        chk({tag, ".edge_seen"}, 32'(bus.dco_edge), 32'd1);
    endtask

    task automatic measure(input string tag, input int exp);
        int n = 0;
        do begin
            cyc(tag);
            n++;
        end while (bus.dco_edge !== 1'b1 && n < 600);
        chk({tag, ".half_period"}, 32'(n), 32'(exp));
    endtask

    task automatic div_rise(output int n, output int edges);
        logic p;
        n = 0;
        edges = 0;
        do begin
            p = bus.dco_div;
            cyc("div");
            n++;
            if (bus.dco_edge === 1'b1) edges++;
        end while (!(p === 1'b0 && bus.dco_div === 1'b1) && n < 400);
    endtask

    task automatic reset_seq(input bit async_chk);
        reset = 1'b1;
        model_reset();
        if (async_chk) begin
            #1;
            chk_all("async_reset");
        end
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_ctrl(input int thr, input int off, input int k, input int c, input bit s);
        bus.thresh_val = W'(thr);
        bus.dco_offset = W'(off);
        bus.kdco       = KW'(k);
        bus.ctrl       = CW'(c);
        bus.ctrl_sign  = s;
    endtask

    initial begin
        int n, edges;
        bus.en = 1'b0;
        bus.hold = 1'b0;
        set_ctrl(9, 0, 0, 0, 1'b0);
        reset_seq(1'b0);

        // Nominal: first enabled edge toggles, then 10-cycle half periods.
        bus.en = 1'b1;
        cyc("first");
        chk("first.dco_clk", 32'(bus.dco_clk), 32'd1);
        chk("nom.thr_out", 32'(bus.thr_out), 32'd9);
        measure("nom", 10);
        measure("nom2", 10);
        bus.dco_offset = W'(5);
        sync_edge("off5");
        chk("off5.thr_out", 32'(bus.thr_out), 32'd14);
        measure("off5", 10);

        // Signed control and mid-half-period change.
        set_ctrl(9, 0, 3, 4, 1'b1);
        sync_edge("neg");
        chk("neg.thr_out", 32'(bus.thr_out), 32'd3);
        measure("neg", 4);
        bus.ctrl_sign = 1'b0;
        sync_edge("pos");
        chk("pos.thr_out", 32'(bus.thr_out), 32'd15);
        repeat (3) cyc("mid");
        bus.ctrl_sign = 1'b1;
        measure("mid_keep", 13);
        measure("mid_new", 4);

        // Saturation both ways.
        set_ctrl(250, 0, 15, 63, 1'b0);
        sync_edge("sathi");
        chk("sathi.thr_out", 32'(bus.thr_out), 32'd255);
        chk("sathi.flag", 32'(bus.sat_hi), 32'd1);
        measure("sathi", 256);
        set_ctrl(10, 0, 15, 63, 1'b1);
        sync_edge("satlo");
        chk("satlo.thr_out", 32'(bus.thr_out), 32'd0);
        chk("satlo.flag", 32'(bus.sat_lo), 32'd1);
        measure("satlo", 1);
        measure("satlo2", 1);

        // Hold freezes the threshold; release applies at the next toggle.
        set_ctrl(9, 0, 0, 0, 1'b0);
        sync_edge("hold_pre");
        measure("hold_pre", 10);
        bus.hold = 1'b1;
        set_ctrl(9, 0, 3, 4, 1'b1);
        sync_edge("hold");
        chk("hold.thr_out", 32'(bus.thr_out), 32'd9);
        measure("hold", 10);
        bus.hold = 1'b0;
        sync_edge("unhold");
        measure("unhold", 4);

        // Enable low for 7 cycles freezes everything.
        repeat (2) cyc("en_pre");
        bus.en = 1'b0;
        repeat (7) cyc("en_off");
        chk("en_off.edge", 32'(bus.dco_edge), 32'd0);
        bus.en = 1'b1;
        measure("en_resume", 2);

        // Divider in the nominal configuration.
        set_ctrl(9, 0, 0, 0, 1'b0);
        div_rise(n, edges);
        div_rise(n, edges);
        chk("div.period", 32'(n), 32'd80);
        chk("div.edges", 32'(edges), 32'd8);
        chk("div.clk_aligned", 32'(bus.dco_clk), 32'd1);

        // Randomised control against the model.
        for (int i = 0; i < 400; i++) begin
            bus.en         = ($urandom_range(0, 9) != 0);
            bus.hold       = ($urandom_range(0, 4) == 0);
            bus.kdco       = KW'($urandom);
            bus.ctrl       = CW'($urandom);
            bus.ctrl_sign  = 1'($urandom);
            bus.thresh_val = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 40));
            bus.dco_offset = W'($urandom_range(0, 20));
            cyc("rand");
        end

        // Asynchronous reset mid-run, then restart.
        bus.en = 1'b1;
        bus.hold = 1'b0;
        set_ctrl(9, 0, 0, 0, 1'b0);
        repeat (3) cyc("pre_reset");
        reset_seq(1'b1);
        cyc("restart");
        chk("restart.dco_clk", 32'(bus.dco_clk), 32'd1);
        measure("restart", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
